// File: rtl/mul4_share_arb_pkg.sv
// mul4_share_arb_pkg: shared widths and latency for the shared a*b*c*d multiplier front end
package mul4_share_arb_pkg;
  localparam int OPW = 10;
  localparam int P2W = 2 * OPW;
  localparam int PW = 4 * OPW;
  localparam int MUL_LAT = 4;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mul4_pipe.sv
// mul4_pipe: four-stage unsigned a*b*c*d datapath with a valid bit alongside, never stalls
module mul4_pipe
  import mul4_share_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [OPW-1:0] c,
  input  logic [OPW-1:0] d,
  output logic           out_valid,
  output logic [PW-1:0]  out_result
);
  logic [P2W-1:0] p0, p1, q0, q1;
  logic [PW-1:0] prod;
  logic [2:0] v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0;
      p1 <= '0;
      q0 <= '0;
      q1 <= '0;
      prod <= '0;
      v <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
    end else begin
      p0 <= P2W'(a) * P2W'(b);
      p1 <= P2W'(c) * P2W'(d);
      q0 <= p0;
      q1 <= p1;
      prod <= PW'(q0) * PW'(q1);
      v <= {v[1:0], in_valid};
      out_valid <= v[2];
      // result holds its last value between strobes
      if (v[2]) out_result <= prod;
    end
  end
endmodule

// File: rtl/mul4_share_arb.sv
// mul4_share_arb: round-robin arbiter issuing one operand set per cycle into a shared mul4_pipe, ID tagged
module mul4_share_arb
  import mul4_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = id_w(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ*OPW-1:0] req_c,
  input  logic [NREQ*OPW-1:0] req_d,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  output logic [IDW-1:0]      out_id,
  output logic [PW-1:0]       out_result,
  output logic                busy
);
  logic [IDW-1:0] ptr, gid;
  logic found;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [MUL_LAT-1];
  always_comb begin
    found = 1'b0;
    gid = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gid = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    // no grants while held in reset
    found = found && rst_n;
    req_ready = found ? (NREQ'(1) << gid) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      tag_v <= '0;
      out_id <= '0;
      for (int k = 0; k < MUL_LAT - 1; k++) tag_id[k] <= '0;
    end else begin
      if (found) ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
      tag_v <= {tag_v[MUL_LAT-2:0], found};
      tag_id[0] <= gid;
      for (int k = 1; k < MUL_LAT - 1; k++) tag_id[k] <= tag_id[k-1];
      if (tag_v[MUL_LAT-2]) out_id <= tag_id[MUL_LAT-2];
    end
  end
  assign busy = |tag_v;
  mul4_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (found),
    .a         (req_a[gid*OPW +: OPW]),
    .b         (req_b[gid*OPW +: OPW]),
    .c         (req_c[gid*OPW +: OPW]),
    .d         (req_d[gid*OPW +: OPW]),
    .out_valid (out_valid),
    .out_result(out_result)
  );
endmodule
